multdiv_ctrl: RTL and testbench
===============================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 3, meaning the MULT/MULTU start-to-done cycle count (legal 2..8).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port start  in  1  request from execute stage, sampled only in IDLE.
REQ-005 SHALL have port op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  in  32  rs operand (multiplicand/dividend).
REQ-007 SHALL have port b  in  32  rt operand (multiplier/divisor).
REQ-008 SHALL have port flush  in  1  exception/redirect kill of the in-flight operation.
REQ-009 SHALL have port busy  out  1  operation in flight; drives the hazard unit's stall.
REQ-010 SHALL have port done  out  1  one-cycle pulse; hi/lo hold the new result.
REQ-011 SHALL have ports hi and lo  out  32 each  result registers, fed to the writeback hi/lo write request.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX, DONE; DONE always returns to IDLE next cycle.
REQ-013 SHALL, in IDLE with start=1 and flush=0 in cycle T, latch a, b and op; go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-014 SHALL ignore start in every state other than IDLE.
REQ-015 SHALL hold busy=1 in MUL, DIV and FIX; busy=0 in IDLE and DONE.
REQ-016 SHALL drive done=1 only in DONE; hi/lo update on entry to DONE and hold until the next DONE.
REQ-017 SHALL, for MULT/MULTU, form the 64-bit signed/unsigned product {hi,lo} and assert done in cycle T+MULT_LATENCY.
REQ-018 SHALL, for DIV/DIVU, run a restoring radix-2 divider on 32-bit magnitudes: one quotient bit per cycle for cycles T+1..T+32, sign fix in FIX (T+33), done at T+34.
REQ-019 SHALL, for DIV: quotient negative iff operand signs differ; remainder takes the dividend's sign; lo=quotient, hi=remainder.
REQ-020 SHALL produce lo=32'h8000_0000, hi=0 for DIV 32'h8000_0000 / 32'hFFFF_FFFF (truncating wrap).
REQ-021 SHALL, when b=0 for DIV/DIVU, skip iteration: FIX at T+1, done at T+2, lo=32'hFFFF_FFFF, hi=a.
REQ-022 SHALL, on flush=1 in any state, go to IDLE next cycle with no done and hi/lo unchanged; flush overrides a same-cycle start.
REQ-023 SHALL accept a new start in the IDLE cycle immediately following DONE (one-cycle turnaround).

Reset
REQ-024 SHALL, while resetn=0 (independent of clk), force state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
REQ-025 SHALL abandon any operation on reset mid-flight; no done after resetn deasserts until a new start.

Structure
REQ-026 SHALL take multdiv_op_t (2-bit enum) and the state enum from a shared package multdiv_pkg, imported by execute and hazard logic.
REQ-027 SHALL place the iterative divider datapath (remainder/quotient shift registers, 6-bit counter) in sub-module div_iter; multiplier pipeline and FSM stay in multdiv_ctrl.

Verification
REQ-028 SHALL cover: MULT a=32'hFFFF_FFFD(-3), b=5 -> done at T+3, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1; MULTU same operands -> hi=4, lo=32'hFFFF_FFF1.
REQ-029 SHALL cover: DIVU a=100, b=7 -> busy T+1..T+33, done at T+34, lo=14, hi=2.
REQ-030 SHALL cover: DIV a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
REQ-031 SHALL cover: DIVU a=9, b=0 -> done at T+2, lo=32'hFFFF_FFFF, hi=9.
REQ-032 SHALL cover: DIVU started at T, flush at T+10 -> busy=0 at T+11, no done through T+40, hi/lo keep prior values; start+flush together in IDLE -> no operation starts.
REQ-033 SHALL cover: resetn low at T+5 of a DIV -> hi=lo=0, busy=0 immediately, no later done; start during busy ignored (result matches the first operation only).

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit, also imported by the execute
// and hazard logic.
package multdiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } multdiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } multdiv_state_t;

    // Magnitude of a 32-bit operand; -2^31 maps onto 32'h8000_0000 unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Execute-stage request / result bundle for the multiply/divide unit.
interface multdiv_ctrl_if;
    import multdiv_pkg::*;

    logic        start;
    multdiv_op_t op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/multdiv_ctrl_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [5:0]  cnt;
    logic [32:0] rem_sh;
    logic [32:0] diff;

    // Dividend bits shift out of quo into rem while quotient bits shift in.
    always_comb begin
        rem_sh = {rem, quo[31]};
        diff   = rem_sh - {1'b0, dsr};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dsr <= divisor;
            cnt <= '0;
        end else if (step) begin
            rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
            quo <= {quo[30:0], ~diff[32]};
            cnt <= cnt + 6'd1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign last      = (cnt == 6'd31);
endmodule

// File: rtl/multdiv_ctrl.sv
// HI/LO multiply/divide controller: fixed-latency multiply, 32-step iterative
// divide with sign fix-up, flush and one-cycle turnaround.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 3
) (
    input logic           clk,
    input logic           resetn,
    multdiv_ctrl_if.slave bus
);
    localparam logic [2:0] MUL_CNT_INIT = 3'(MULT_LATENCY - 2);

    multdiv_state_t state, state_d;
    multdiv_op_t    op_q;
    logic [31:0]    a_q, b_q;
    logic           div0_q;
    logic [2:0]     mul_cnt;
    logic [31:0]    hi, lo;

    logic        accept;
    logic        div_last;
    logic [31:0] quo, rem;
    logic [31:0] dvd_mag, dvs_mag;

    assign accept  = (state == ST_IDLE) && bus.start && !bus.flush;
    assign dvd_mag = mag32(bus.a, bus.op == OP_DIV);
    assign dvs_mag = mag32(bus.b, bus.op == OP_DIV);

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept && bus.op[1]),
        .step      (state == ST_DIV),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (quo),
        .remainder (rem),
        .last      (div_last)
    );

    logic        mul_signed, div_signed, q_neg, r_neg;
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] div_hi, div_lo;

    // Low 64 bits of the 64x64 product of extended operands equal the exact
    // signed or unsigned 32x32 product.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
        a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
        b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
        product    = a_ext * b_ext;
        div_signed = (op_q == OP_DIV);
        q_neg      = div_signed & (a_q[31] ^ b_q[31]);
        r_neg      = div_signed & a_q[31];
        div_lo     = div0_q ? '1  : (q_neg ? (~quo + 32'd1) : quo);
        div_hi     = div0_q ? a_q : (r_neg ? (~rem + 32'd1) : rem);
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (accept) state_d = !bus.op[1] ? ST_MUL : ((bus.b == '0) ? ST_FIX : ST_DIV);
            ST_MUL:  if (mul_cnt == '0) state_d = ST_DONE;
            ST_DIV:  if (div_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            div0_q  <= 1'b0;
            mul_cnt <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                op_q    <= bus.op;
                a_q     <= bus.a;
                b_q     <= bus.b;
                div0_q  <= (bus.b == '0);
                mul_cnt <= MUL_CNT_INIT;
            end else if (state == ST_MUL && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - 3'd1;
            end
            // Flush forces state_d to IDLE, so a killed operation never writes.
            if (state_d == ST_DONE) begin
                if (state == ST_MUL) begin
                    {hi, lo} <= product;
                end else begin
                    hi <= div_hi;
                    lo <= div_lo;
                end
            end
        end
    end

    assign bus.busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign bus.done = (state == ST_DONE);
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with hand-computed results and cycle timing.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    multdiv_ctrl_if bus ();

    multdiv_ctrl #(.MULT_LATENCY(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start in cycle T; observe cycles T+1..T+cycles at the falling edge.
    // flush_at=k asserts flush during T+k; noise_until=n keeps start high in T+1..T+n-1.
    task automatic run_op(input multdiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input int cycles, input int flush_at, input int noise_until,
                          output int done_at, output int done_cnt, output logic [63:0] busy_vec);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.flush = 1'b0;
        done_at = -1; done_cnt = 0; busy_vec = '0;
        for (int k = 1; k <= cycles; k++) begin
            @(posedge clk); #1;
            bus.flush = (k == flush_at);
            if (k < noise_until) begin
                bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd2; bus.b = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            busy_vec[k] = bus.busy;
        end
        bus.start = 1'b0; bus.flush = 1'b0;
    endtask

    int          d_at, d_cnt, b_cnt;
    logic [63:0] bv;

    initial begin
        bus.start = 1'b0; bus.op = OP_MULT; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        resetn = 1'b1;

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 3, 0, 0, d_at, d_cnt, bv);
        check("mult_done_at", 64'(d_at), 64'd3);
        check("mult_busy", bv, 64'h6);
        check("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        // Started in the IDLE cycle right after DONE.
        run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5, 4, 0, 0, d_at, d_cnt, bv);
        check("multu_done_at", 64'(d_at), 64'd3);
        check("multu_done_cnt", 64'(d_cnt), 64'd1);
        check("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0004_FFFF_FFF1);

        run_op(OP_DIVU, 32'd100, 32'd7, 36, 0, 0, d_at, d_cnt, bv);
        check("divu_done_at", 64'(d_at), 64'd34);
        check("divu_busy", bv, 64'h3_FFFF_FFFE);
        check("divu_done_cnt", 64'(d_cnt), 64'd1);
        check("divu_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 36, 0, 0, d_at, d_cnt, bv);
        check("div_neg_done_at", 64'(d_at), 64'd34);
        check("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 36, 0, 0, d_at, d_cnt, bv);
        check("div_wrap_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

        run_op(OP_DIVU, 32'd9, 32'd0, 4, 0, 0, d_at, d_cnt, bv);
        check("div0_done_at", 64'(d_at), 64'd2);
        check("div0_busy", bv, 64'h2);
        check("div0_hilo", {bus.hi, bus.lo}, 64'h0000_0009_FFFF_FFFF);

        run_op(OP_DIVU, 32'd50, 32'd3, 40, 10, 0, d_at, d_cnt, bv);
        check("flush_busy", bv, 64'h7FE);
        check("flush_done_cnt", 64'(d_cnt), 64'd0);
        check("flush_hilo", {bus.hi, bus.lo}, 64'h0000_0009_FFFF_FFFF);

        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        d_cnt = 0; b_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done) d_cnt++;
            if (bus.busy) b_cnt++;
        end
        check("stflush_busy", 64'(b_cnt), 64'd0);
        check("stflush_done", 64'(d_cnt), 64'd0);
        check("stflush_hilo", {bus.hi, bus.lo}, 64'h0000_0009_FFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd7, 36, 0, 20, d_at, d_cnt, bv);
        check("ignore_done_at", 64'(d_at), 64'd34);
        check("ignore_done_cnt", 64'(d_cnt), 64'd1);
        check("ignore_hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});

        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        d_cnt = 0; b_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) d_cnt++;
            if (bus.busy) b_cnt++;
        end
        check("postrst_done", 64'(d_cnt), 64'd0);
        check("postrst_busy", 64'(b_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
